// File: rtl/ctrl_decode_stage_if.sv
// Handshake/bus bundle between the ID stage and the main-control stage.
//   i_instruccion/i_valid  : instruction currently in ID and its qualifier
//   i_stall/i_flush        : hazard-unit hold and branch-taken kill
//   i_step_mode/i_step     : debug single-step gate
//   o_ex/o_mem/o_wb/o_valid: registered ID/EX control bundle
//   o_illegal              : one-cycle pulse, unknown opcode accepted
//   o_halt_seen/o_halted   : sticky HALT progress flags
//   o_pc_write             : combinational PC / IF-ID advance enable
interface ctrl_decode_stage_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] i_instruccion;
  logic                  i_valid;
  logic                  i_stall;
  logic                  i_flush;
  logic                  i_step_mode;
  logic                  i_step;
  logic [3:0]            o_ex;
  logic [2:0]            o_mem;
  logic [1:0]            o_wb;
  logic                  o_valid;
  logic                  o_illegal;
  logic                  o_halt_seen;
  logic                  o_halted;
  logic                  o_pc_write;

  modport master (
    output i_instruccion, i_valid, i_stall, i_flush, i_step_mode, i_step,
    input  o_ex, o_mem, o_wb, o_valid, o_illegal, o_halt_seen, o_halted, o_pc_write
  );

  modport slave (
    input  i_instruccion, i_valid, i_stall, i_flush, i_step_mode, i_step,
    output o_ex, o_mem, o_wb, o_valid, o_illegal, o_halt_seen, o_halted, o_pc_write
  );
endinterface

// File: rtl/ctrl_decode_stage.sv
// Main-control stage of the 5-stage MIPS pipeline. Decodes the ID
// instruction into EX/MEM/WB control bundles registered at the ID/EX
// boundary, inserts bubbles on stall/flush/single-step, and runs the HALT
// drain machine (RUN -> DRAIN -> HALTED) that freezes fetch.
// Ports:
//   i_clk   : clock, all state on rising edge
//   i_reset : synchronous reset, active low
//   bus     : ctrl_decode_stage_if slave (instruction in, control bundle out)
module ctrl_decode_stage #(
  parameter int DATA_WIDTH   = 32,
  parameter int SIZEOP       = 6,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic                i_clk,
  input  logic                i_reset,
  ctrl_decode_stage_if.slave  bus
);
  localparam int CW = $clog2(DRAIN_CYCLES) + 1;

  localparam logic [SIZEOP-1:0] OP_R    = SIZEOP'(6'b000000);
  localparam logic [SIZEOP-1:0] OP_LW   = SIZEOP'(6'b100011);
  localparam logic [SIZEOP-1:0] OP_SW   = SIZEOP'(6'b101011);
  localparam logic [SIZEOP-1:0] OP_BEQ  = SIZEOP'(6'b000100);
  localparam logic [SIZEOP-1:0] OP_ADDI = SIZEOP'(6'b001000);
  localparam logic [SIZEOP-1:0] OP_ANDI = SIZEOP'(6'b001100);
  localparam logic [SIZEOP-1:0] OP_ORI  = SIZEOP'(6'b001101);
  localparam logic [SIZEOP-1:0] OP_XORI = SIZEOP'(6'b001110);
  localparam logic [SIZEOP-1:0] OP_LUI  = SIZEOP'(6'b001111);
  localparam logic [SIZEOP-1:0] OP_SLTI = SIZEOP'(6'b001010);
  localparam logic [SIZEOP-1:0] OP_NOP  = SIZEOP'(6'b111000);
  localparam logic [SIZEOP-1:0] OP_HALT = SIZEOP'(6'b111111);

  typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, HALTED = 2'd2} state_t;

  state_t            state, state_nxt;
  logic [CW-1:0]     cnt, cnt_nxt;
  logic [SIZEOP-1:0] opcode;
  logic [3:0]        dec_ex;
  logic [2:0]        dec_mem;
  logic [1:0]        dec_wb;
  logic              dec_known, dec_halt;
  logic              step_ok, accept;
  logic              unused_operand_bits;

  assign opcode = bus.i_instruccion[DATA_WIDTH-1 -: SIZEOP];
  // Operand fields are decoded downstream, not here.
  assign unused_operand_bits = ^bus.i_instruccion[DATA_WIDTH-SIZEOP-1:0];

  // In step mode each i_step cycle admits one instruction; a held step
  // therefore admits one per cycle.
  assign step_ok        = ~bus.i_step_mode | bus.i_step;
  assign accept         = bus.i_valid & (state == RUN) & ~bus.i_stall & ~bus.i_flush & step_ok;
  assign bus.o_pc_write = (state == RUN) & ~bus.i_stall & step_ok;

  always_comb begin
    dec_ex    = '0;
    dec_mem   = '0;
    dec_wb    = '0;
    dec_known = 1'b1;
    dec_halt  = 1'b0;
    case (opcode)
      OP_R:   begin dec_ex = 4'b1100; dec_wb = 2'b10; end
      OP_LW:  begin dec_ex = 4'b0001; dec_mem = 3'b100; dec_wb = 2'b11; end
      OP_SW:  begin dec_ex = 4'b0001; dec_mem = 3'b010; end
      OP_BEQ: begin dec_ex = 4'b0010; dec_mem = 3'b001; end
      OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_LUI, OP_SLTI:
              begin dec_ex = 4'b0111; dec_wb = 2'b10; end
      OP_NOP: ;
      OP_HALT: dec_halt = 1'b1;
      default: dec_known = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      RUN: if (accept && dec_halt) begin
        state_nxt = DRAIN;
        cnt_nxt   = CW'(DRAIN_CYCLES - 1);
      end
      DRAIN: begin
        if (cnt == '0) state_nxt = HALTED;
        else           cnt_nxt   = cnt - CW'(1);
      end
      HALTED: ;
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state           <= RUN;
      cnt             <= '0;
      bus.o_ex        <= '0;
      bus.o_mem       <= '0;
      bus.o_wb        <= '0;
      bus.o_valid     <= 1'b0;
      bus.o_illegal   <= 1'b0;
      bus.o_halt_seen <= 1'b0;
      bus.o_halted    <= 1'b0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      bus.o_ex      <= accept ? dec_ex  : '0;
      bus.o_mem     <= accept ? dec_mem : '0;
      bus.o_wb      <= accept ? dec_wb  : '0;
      bus.o_valid   <= accept & dec_known;
      bus.o_illegal <= accept & ~dec_known;
      if (accept && dec_halt)               bus.o_halt_seen <= 1'b1;
      if (state == DRAIN && cnt == '0)      bus.o_halted    <= 1'b1;
    end
  end
endmodule
